// File: rtl/count_bounce_multi_pkg.sv
// Shared types and step normalisation for the multi-mode bounce counter.
// Pure definitions: no latency, no backpressure.
package count_pkg;

  typedef enum logic [1:0] {
    UP_WRAP = 2'd0,
    DN_WRAP = 2'd1,
    BOUNCE  = 2'd2,
    UP_SAT  = 2'd3
  } mode_e;

  localparam int MAX_B = 32;

  // A zero step would stall the counter forever, so it behaves as a step of one.
  function automatic logic [MAX_B-1:0] eff_step(input logic [MAX_B-1:0] step, input int b);
    logic [MAX_B-1:0] mask;
    mask = (b >= MAX_B) ? '1 : ((MAX_B'(1) << b) - MAX_B'(1));
    return ((step & mask) == '0) ? MAX_B'(1) : (step & mask);
  endfunction

endpackage

// File: rtl/count_bounce_multi_if.sv
// Control/status bundle of the bounce counter; COUNT_LOAD_EN adds ld/ld_val.
// Wires only: no latency, no backpressure.
interface count_bounce_multi_if #(parameter int B = 4);
  import count_pkg::*;

  logic         inc;
  mode_e        mode;
  logic [B-1:0] lim;
  logic [B-1:0] step;
`ifdef COUNT_LOAD_EN
  logic         ld;
  logic [B-1:0] ld_val;
`endif
  logic [B-1:0] cnt;
  logic         dir;
  logic         tc;

`ifdef COUNT_LOAD_EN
  modport master (output inc, mode, lim, step, ld, ld_val, input cnt, dir, tc);
  modport slave  (input inc, mode, lim, step, ld, ld_val, output cnt, dir, tc);
`else
  modport master (output inc, mode, lim, step, input cnt, dir, tc);
  modport slave  (input inc, mode, lim, step, output cnt, dir, tc);
`endif

endinterface

// File: rtl/count_bounce_multi_bounce_dir.sv
// Direction flag: set at the top turn, cleared at the bottom turn, forced by mode.
// One cycle latency; no backpressure, updates every cycle.
module bounce_dir (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic force_en,
  input  logic force_val,
  output logic dir
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir <= 1'b0;
    end else if (force_en) begin
      dir <= force_val;
    end else if (set) begin
      dir <= 1'b1;
    end else if (clr) begin
      dir <= 1'b0;
    end
  end

endmodule

// File: rtl/count_bounce_multi.sv
// Multi-mode step counter (wrap up/down, bounce, saturate); COUNT_LOAD_EN adds a load.
// One cycle from inc/ld to cnt/dir/tc; no backpressure, one step per accepted inc.
module count_bounce_multi
  import count_pkg::*;
#(
  parameter int B       = 4,
  parameter int LIM_RST = 14
) (
  input logic              clk,
  input logic              rst,
  count_bounce_multi_if.slave bus
);

  if (LIM_RST < 0 || LIM_RST >= (2 ** B)) begin : g_bad_lim_rst
    $error("LIM_RST does not fit in B bits");
  end

  logic [B-1:0] s;
  logic [B:0]   sum;
  logic [B-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         dir_q, dir_set, dir_clr;
  logic         upd;

  assign s   = B'(eff_step(MAX_B'(bus.step), B));
  assign sum = {1'b0, cnt_q} + {1'b0, s};

`ifdef COUNT_LOAD_EN
  assign upd = bus.inc | bus.ld;
`else
  assign upd = bus.inc;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    dir_set = 1'b0;
    dir_clr = 1'b0;
`ifdef COUNT_LOAD_EN
    if (bus.ld) begin
      cnt_d = (bus.ld_val > bus.lim) ? bus.lim : bus.ld_val;
    end else
`endif
    if (bus.inc) begin
      // A lowered limit pulls the count back in before any mode rule applies.
      if (cnt_q > bus.lim) begin
        cnt_d = bus.lim;
      end else begin
        unique case (bus.mode)
          UP_WRAP: begin
            if (sum > {1'b0, bus.lim}) begin
              cnt_d = '0;
              tc_d  = 1'b1;
            end else begin
              cnt_d = sum[B-1:0];
            end
          end
          DN_WRAP: begin
            if (cnt_q < s) begin
              cnt_d = bus.lim;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - s;
            end
          end
          BOUNCE: begin
            if (!dir_q) begin
              if (sum >= {1'b0, bus.lim}) begin
                cnt_d   = bus.lim;
                dir_set = 1'b1;
                tc_d    = 1'b1;
              end else begin
                cnt_d = sum[B-1:0];
              end
            end else begin
              if (cnt_q <= s) begin
                cnt_d   = '0;
                dir_clr = 1'b1;
                tc_d    = 1'b1;
              end else begin
                cnt_d = cnt_q - s;
              end
            end
          end
          UP_SAT: begin
            // tc only on arrival, so sitting at the limit stays quiet.
            if (sum >= {1'b0, bus.lim}) begin
              cnt_d = bus.lim;
              tc_d  = (cnt_q != bus.lim);
            end else begin
              cnt_d = sum[B-1:0];
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (upd) begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  bounce_dir u_dir (
    .clk       (clk),
    .rst       (rst),
    .set       (dir_set),
    .clr       (dir_clr),
    .force_en  (bus.mode != BOUNCE),
    .force_val (bus.mode == DN_WRAP),
    .dir       (dir_q)
  );

  assign bus.cnt = cnt_q;
  assign bus.dir = dir_q;
  assign bus.tc  = tc_q;

endmodule

// File: tb/tb_count_bounce_multi.sv
// Scoreboard bench for count_bounce_multi; load vectors run when COUNT_LOAD_EN is defined.
module tb_count_bounce_multi;
  import count_pkg::*;

  localparam int B = 4;

  typedef struct {
    int       tag;
    logic [3:0] cnt;
    logic     dir;
    logic     tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   vec_n  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  count_bounce_multi_if #(.B(B)) bus ();

  count_bounce_multi #(.B(B), .LIM_RST(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge that a driven vector covers.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cnt", mon_e.tag, 8'(bus.cnt), 8'(mon_e.cnt));
      chk("dir", mon_e.tag, 8'(bus.dir), 8'(mon_e.dir));
      chk("tc",  mon_e.tag, 8'(bus.tc),  8'(mon_e.tc));
    end
  end

  task automatic push_exp(input int ec, input int ed, input int et);
    exp_t e;
    e.tag = vec_n;
    e.cnt = 4'(ec);
    e.dir = 1'(ed);
    e.tc  = 1'(et);
    vec_n++;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic inc, input mode_e m, input int lim, input int step,
                       input int ec, input int ed, input int et);
    bus.inc  = inc;
    bus.mode = m;
    bus.lim  = 4'(lim);
    bus.step = 4'(step);
`ifdef COUNT_LOAD_EN
    bus.ld     = 1'b0;
    bus.ld_val = '0;
`endif
    push_exp(ec, ed, et);
    @(negedge clk);
  endtask

`ifdef COUNT_LOAD_EN
  task automatic drive_ld(input mode_e m, input int lim, input int ld_val,
                          input int ec, input int ed, input int et);
    bus.inc    = 1'b1;
    bus.mode   = m;
    bus.lim    = 4'(lim);
    bus.step   = 4'd1;
    bus.ld     = 1'b1;
    bus.ld_val = 4'(ld_val);
    push_exp(ec, ed, et);
    @(negedge clk);
  endtask
`endif

  // Called at a falling edge; reset must clear outputs without waiting for a clock.
  task automatic do_reset(input string nm);
    bus.inc = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk({nm, "_cnt"}, -1, 8'(bus.cnt), 8'd0);
    chk({nm, "_dir"}, -1, 8'(bus.dir), 8'd0);
    chk({nm, "_tc"},  -1, 8'(bus.tc),  8'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int bc[11] = '{3, 6, 9, 12, 13, 10, 7, 4, 1, 0, 3};
  int bd[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
  int bt[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inc  = 1'b0;
    bus.mode = UP_WRAP;
    bus.lim  = 4'd13;
    bus.step = 4'd1;
`ifdef COUNT_LOAD_EN
    bus.ld     = 1'b0;
    bus.ld_val = '0;
`endif
    #1;
    chk("rst_cnt", -1, 8'(bus.cnt), 8'd0);
    chk("rst_dir", -1, 8'(bus.dir), 8'd0);
    chk("rst_tc",  -1, 8'(bus.tc),  8'd0);
    @(negedge clk);
    rst = 1'b1;

    // UP_WRAP, lim 13, step 1: 1..13, wrap to 0 with tc, then on to 3.
    for (int i = 1; i <= 17; i++) drive(1'b1, UP_WRAP, 13, 1, i % 14, 0, (i == 14) ? 1 : 0);
    bus.inc = 1'b0;
    do_reset("midrun");

    // BOUNCE, lim 13, step 3: endpoints each held for one step.
    for (int i = 0; i < 11; i++) drive(1'b1, BOUNCE, 13, 3, bc[i], bd[i], bt[i]);
    do_reset("rst2");

    // DN_WRAP, lim 5, step 0 (acts as 1), with one idle cycle after the first wrap.
    drive(1'b1, DN_WRAP, 5, 0, 5, 1, 1);
    drive(1'b0, DN_WRAP, 5, 0, 5, 1, 0);
    for (int v = 4; v >= 0; v--) drive(1'b1, DN_WRAP, 5, 0, v, 1, 0);
    drive(1'b1, DN_WRAP, 5, 0, 5, 1, 1);
    do_reset("rst3");

    // UP_SAT, lim 9, step 4, then lim lowered to 6.
    drive(1'b1, UP_SAT, 9, 4, 4, 0, 0);
    drive(1'b1, UP_SAT, 9, 4, 8, 0, 0);
    drive(1'b1, UP_SAT, 9, 4, 9, 0, 1);
    drive(1'b1, UP_SAT, 9, 4, 9, 0, 0);
    drive(1'b1, UP_SAT, 6, 4, 6, 0, 0);
    drive(1'b1, UP_SAT, 6, 4, 6, 0, 0);
    do_reset("rst4");

    // lim 0 in BOUNCE: tc on every inc, dir alternates; then switch to UP_WRAP.
    drive(1'b1, BOUNCE, 0, 1, 0, 1, 1);
    drive(1'b1, BOUNCE, 0, 1, 0, 0, 1);
    drive(1'b1, BOUNCE, 0, 1, 0, 1, 1);
    drive(1'b0, BOUNCE, 0, 1, 0, 1, 0);
    drive(1'b1, UP_WRAP, 13, 1, 1, 0, 0);
    drive(1'b1, UP_WRAP, 13, 1, 2, 0, 0);

`ifdef COUNT_LOAD_EN
    // Load beats inc and clamps to lim; reaching lim by load gives no tc later.
    drive_ld(UP_SAT, 13, 15, 13, 0, 0);
    drive(1'b1, UP_SAT, 13, 1, 13, 0, 0);
`endif

    bus.inc = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("drain", -1, 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
